// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-ALU endpoint: FSM state encodings and
// the opcode values understood by the attached ALU.
package uart_pkg;

  localparam logic [2:0] S_GET_A   = 3'd0;
  localparam logic [2:0] S_GET_B   = 3'd1;
  localparam logic [2:0] S_GET_OP  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    GET_A   = S_GET_A,
    GET_B   = S_GET_B,
    GET_OP  = S_GET_OP,
    EXEC    = S_EXEC,
    WAIT_TX = S_WAIT_TX
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // States in which the frame collector is waiting on the next RX byte.
  function automatic logic is_rx_wait(state_t s);
    return (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_if_if.sv
// Signal bundle between the UART RX/TX blocks, the ALU and the frame endpoint.
// Handshake: rx_done_tick/tx_done_tick/tick/tx_start/overrun are 1-cycle pulses
// (no back-pressure); data buses are valid while their pulse is high.
interface uart_alu_if_if #(
  parameter int NBIT_DATA = 8,
  parameter int NBIT_OP   = 6
);
  logic                 tick;
  logic                 rx_done_tick;
  logic [NBIT_DATA-1:0] rx_data;
  logic                 tx_done_tick;
  logic [NBIT_DATA-1:0] alu_result;
  logic [NBIT_DATA-1:0] op_a;
  logic [NBIT_DATA-1:0] op_b;
  logic [NBIT_OP-1:0]   op_code;
  logic                 tx_start;
  logic [NBIT_DATA-1:0] tx_data;
  logic                 busy;
  logic                 overrun;

  modport master (
    output tick, rx_done_tick, rx_data, tx_done_tick, alu_result,
    input  op_a, op_b, op_code, tx_start, tx_data, busy, overrun
  );

  modport slave (
    input  tick, rx_done_tick, rx_data, tx_done_tick, alu_result,
    output op_a, op_b, op_code, tx_start, tx_data, busy, overrun
  );
endinterface

// File: rtl/uart_if_timeout.sv
// Inter-byte timeout: counts baud ticks while enabled, saturates at the last
// count and flags expiry on the tick that would pass it.
module uart_if_timeout #(
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_TICKS);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // A clear in the same cycle (an arriving byte) always beats expiry.
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_alu_if.sv
// Collects an {A, B, opcode} byte frame from UART RX, presents it to the ALU
// and sends the one-byte result back through UART TX.
module uart_alu_if
  import uart_pkg::*;
#(
  parameter int NBIT_DATA     = 8,
  parameter int NBIT_OP       = 6,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic          CLK,
  input  logic          reset,
  uart_alu_if_if.slave  bus,
  output logic [2:0]    dbg_state
);

  state_t               state;
  logic [NBIT_DATA-1:0] op_a_q;
  logic [NBIT_DATA-1:0] op_b_q;
  logic [NBIT_OP-1:0]   op_code_q;
  logic [NBIT_DATA-1:0] tx_data_q;
  logic                 tx_start_q;
  logic                 busy_q;
  logic                 overrun_q;

  logic rx_wait;
  logic to_clear;
  logic to_enable;
  logic to_expired;

  assign rx_wait   = is_rx_wait(state);
  assign to_clear  = bus.rx_done_tick || !rx_wait;
  assign to_enable = bus.tick && rx_wait;

  uart_if_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= GET_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_code_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      case (state)
        GET_A: begin
          if (bus.rx_done_tick) begin
            op_a_q <= bus.rx_data;
            state  <= GET_B;
            busy_q <= 1'b1;
          end
        end
        GET_B: begin
          if (bus.rx_done_tick) begin
            op_b_q <= bus.rx_data;
            state  <= GET_OP;
          end else if (to_expired) begin
            state  <= GET_A;
            busy_q <= 1'b0;
          end
        end
        GET_OP: begin
          if (bus.rx_done_tick) begin
            op_code_q <= bus.rx_data[NBIT_OP-1:0];
            state     <= EXEC;
          end else if (to_expired) begin
            state  <= GET_A;
            busy_q <= 1'b0;
          end
        end
        EXEC: begin
          // Operands were registered last cycle, so the ALU output is settled.
          tx_data_q  <= bus.alu_result;
          tx_start_q <= 1'b1;
          overrun_q  <= bus.rx_done_tick;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          overrun_q <= bus.rx_done_tick;
          if (bus.tx_done_tick) begin
            state  <= GET_A;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= GET_A;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_code  = op_code_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: table-driven frames, timeout/overrun/reset corner
// sequences, and randomized frames checked against a frame-level model.
module tb_uart_alu_if;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  uart_alu_if_if bus ();

  uart_alu_if dut (
    .CLK       (CLK),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  int vec_count = 0;
  int err_count = 0;
  int tx_seen   = 0;
  int ovr_seen  = 0;
  int exp_ovr   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[9];
  logic [5:0] known_ops[8];

  // Environment ALU; unknown opcodes get an arbitrary but fixed result.
  function automatic logic [7:0] alu_model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return a ^ ~b;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.op_a, bus.op_b, bus.op_code);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest expected result.
  always @(negedge CLK) begin
    if (reset === 1'b1 && bus.tx_start === 1'b1) begin
      tx_seen++;
      if (exp_q.size() == 0) begin
        vec_count++;
        err_count++;
        $display("FAIL unexpected_tx_start: got tx_data %0h, want no tx_start", bus.tx_data);
      end else begin
        check("sb_tx_data", bus.tx_data, exp_q.pop_front());
      end
    end
    if (reset === 1'b1 && bus.overrun === 1'b1) ovr_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    cyc();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic end_tx();
    bus.tx_done_tick = 1'b1;
    cyc();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic run_vec(vec_t v);
    exp_q.push_back(v.res);
    send_byte(v.a);
    check("frame_busy_after_a", bus.busy, 1);
    check("frame_state_get_b", dbg_state, S_GET_B);
    send_byte(v.b);
    send_byte(v.op);
    check("frame_op_a", bus.op_a, v.a);
    check("frame_op_b", bus.op_b, v.b);
    check("frame_op_code", bus.op_code, v.op[5:0]);
    check("frame_tx_start_early", bus.tx_start, 0);
    cyc();
    check("frame_tx_start", bus.tx_start, 1);
    check("frame_tx_data", bus.tx_data, v.res);
    cyc();
    check("frame_tx_start_1cyc", bus.tx_start, 0);
    check("frame_busy_wait_tx", bus.busy, 1);
    cyc(2);
    check("frame_tx_data_held", bus.tx_data, v.res);
    end_tx();
    check("frame_busy_done", bus.busy, 0);
    check("frame_state_done", dbg_state, S_GET_A);
  endtask

  initial begin
    bit ok;
    int t0;
    logic [7:0] a, b, op, r;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE};
    vecs[2] = '{8'hF0, 8'h0F, 8'h24, 8'h00};
    vecs[3] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
    vecs[4] = '{8'hAA, 8'hFF, 8'h26, 8'h55};
    vecs[5] = '{8'h80, 8'h02, 8'h03, 8'hE0};
    vecs[6] = '{8'h80, 8'h02, 8'h02, 8'h20};
    vecs[7] = '{8'h0F, 8'hF0, 8'h27, 8'h00};
    vecs[8] = '{8'h12, 8'h34, 8'hE0, 8'h46};
    known_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    reset            = 1'b0;
    bus.tick         = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    bus.tx_done_tick = 1'b0;
    cyc(2);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_op_a", bus.op_a, 0);
    check("rst_op_b", bus.op_b, 0);
    check("rst_op_code", bus.op_code, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_state", dbg_state, S_GET_A);
    reset = 1'b1;
    cyc();

    // A stray tx_done_tick in GET_A changes nothing.
    end_tx();
    check("txdone_ignored_get_a", dbg_state, S_GET_A);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: 639 ticks are tolerated, the 640th returns to GET_A.
    t0 = tx_seen;
    send_byte(8'h11);
    end_tx();
    check("txdone_ignored_get_b", dbg_state, S_GET_B);
    bus.tick = 1'b1;
    cyc(639);
    check("to_busy_before", bus.busy, 1);
    check("to_state_before", dbg_state, S_GET_B);
    cyc();
    bus.tick = 1'b0;
    check("to_busy_after", bus.busy, 0);
    check("to_state_after", dbg_state, S_GET_A);
    check("to_op_a_kept", bus.op_a, 8'h11);
    cyc(3);
    check("to_no_tx_start", tx_seen, t0);
    run_vec(vecs[1]);

    // Byte coincident with the expiring tick is accepted and restarts the count.
    send_byte(8'h40);
    bus.tick = 1'b1;
    cyc(639);
    send_byte(8'h50);
    check("coinc_state", dbg_state, S_GET_OP);
    check("coinc_op_b", bus.op_b, 8'h50);
    cyc(639);
    bus.tick = 1'b0;
    check("coinc_counter_cleared", dbg_state, S_GET_OP);
    exp_q.push_back(8'h90);
    send_byte(8'h20);
    cyc();
    check("coinc_tx_start", bus.tx_start, 1);
    check("coinc_tx_data", bus.tx_data, 8'h90);
    end_tx();

    // Overrun: byte during WAIT_TX is dropped with a 1-cycle pulse.
    exp_q.push_back(8'h08);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    cyc();
    send_byte(8'h77);
    exp_ovr++;
    check("ovr_pulse", bus.overrun, 1);
    cyc();
    check("ovr_pulse_end", bus.overrun, 0);
    check("ovr_op_a_kept", bus.op_a, 8'h05);
    check("ovr_state", dbg_state, S_WAIT_TX);
    end_tx();
    run_vec(vecs[2]);

    // Asynchronous reset in the middle of a transmission.
    exp_q.push_back(8'h08);
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    cyc(2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_tx_data", bus.tx_data, 0);
    check("arst_op_a", bus.op_a, 0);
    check("arst_tx_start", bus.tx_start, 0);
    check("arst_state", dbg_state, S_GET_A);
    cyc(2);
    reset = 1'b1;
    t0 = tx_seen;
    cyc(5);
    check("arst_no_tx_start", tx_seen, t0);
    check("arst_state_after", dbg_state, S_GET_A);

    // Randomized frames with gaps, stray ticks and occasional overruns.
    for (int i = 0; i < 40; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ($urandom_range(0, 1) == 1) ? {2'($urandom), known_ops[$urandom_range(0, 7)]}
                                       : 8'($urandom);
      r  = alu_model(a, b, op[5:0]);
      exp_q.push_back(r);
      send_byte(a);
      for (int g = $urandom_range(0, 4); g > 0; g--) begin
        bus.tick = 1'($urandom_range(0, 1));
        cyc();
      end
      bus.tick = 1'b0;
      send_byte(b);
      cyc($urandom_range(0, 3));
      send_byte(op);
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom));
        exp_ovr++;
      end
      wait_tx_start(ok);
      check("rand_tx_start_seen", ok, 1);
      check("rand_op_a", bus.op_a, a);
      check("rand_op_b", bus.op_b, b);
      check("rand_op_code", bus.op_code, op[5:0]);
      cyc($urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom));
        exp_ovr++;
      end
      check("rand_tx_data_held", bus.tx_data, r);
      end_tx();
      check("rand_busy_done", bus.busy, 0);
    end

    cyc(3);
    check("overrun_count", ovr_seen, exp_ovr);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
